// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle datapath controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // Controller states; the three unused 4-bit encodings fall back to S_RESET.
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_ALUWB_R = 4'd5,
        S_ALUWB_I = 4'd6,
        S_MEMADR  = 4'd7,
        S_MEMRD   = 4'd8,
        S_MEMWB   = 4'd9,
        S_MEMWR   = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_e;

    // Opcodes; 10..15 are illegal.
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_J     = 4'd9;

    // ALU operation classes for the ALU control decoder.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main multi-cycle controller: sequences fetch/decode/execute/memory/write-back.
// Latency: R/I 4, lw 5, sw 4, beq/bne/j 3, illegal 2 cycles with zero-wait memory.
// Backpressure: holds in FETCH/MEMRD/MEMWR with requests asserted until mem_ready.
// Ports: clk, reset (async, active-high); opcode, mem_ready in; datapath enables
// and mux selects, alu_op, illegal_op pulse and retired-instruction count out.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_source,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_op,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    instr_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter wraps naturally at 2^CNT_W.
    assign cnt_d       = retire ? cnt_q + 1'b1 : cnt_q;
    assign instr_count = cnt_q;

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALU_ADD;
        illegal_op    = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                // IR and PC+1 only commit once the instruction word has arrived.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                // Speculative branch-target computation into ALUOut.
                alu_src_b = SRCB_BOFF;
                case (opcode)
                    OPCODE_W'(OP_RTYPE):                  state_d = S_EXEC_R;
                    OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
                    OPCODE_W'(OP_ORI),  OPCODE_W'(OP_SLTI): state_d = S_EXEC_I;
                    OPCODE_W'(OP_LW),   OPCODE_W'(OP_SW):   state_d = S_MEMADR;
                    OPCODE_W'(OP_BEQ),  OPCODE_W'(OP_BNE):  state_d = S_BRANCH;
                    OPCODE_W'(OP_J):                        state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB_R;
            end

            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OPCODE_W'(OP_ANDI): alu_op = ALU_AND;
                    OPCODE_W'(OP_ORI):  alu_op = ALU_OR;
                    OPCODE_W'(OP_SLTI): alu_op = ALU_SLT;
                    default:            alu_op = ALU_ADD;
                endcase
                state_d = S_ALUWB_I;
            end

            S_ALUWB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_ALUWB_I: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = (opcode == OPCODE_W'(OP_BNE));
                retire        = 1'b1;
                state_d       = S_FETCH;
            end

            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Latency: n/a.
// Backpressure: memory waits driven by the bench.
module tb_multicycle_control_fsm;

    // Narrow counter so that wrap-around is reachable in a short run.
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic          pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic          ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]    pc_source, alu_src_b;
    logic [2:0]    alu_op;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPCODE_W(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } out_t;

    function automatic out_t actual();
        out_t a;
        a = '{pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write,
              ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
              illegal_op};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Read and write requests must never overlap.
    always @(negedge clk) begin
        if (!reset) chk("mem_rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
    end

    // One controller cycle: drive mem_ready, compare at the falling edge, advance.
    task automatic step(input out_t e, input logic rdy, input string nm);
        mem_ready = rdy;
        @(negedge clk);
        chk({nm, "_outputs"}, 32'(actual()), 32'(e));
        chk({nm, "_count"}, 32'(instr_count), 32'(exp_cnt[CW-1:0]));
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-cycle expected controls derived from the instruction class.
    task automatic exec(input logic [3:0] op, input int fw, input int mw);
        out_t e;
        opcode = op;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            e.ir_write = (i == fw); e.pc_write = (i == fw);
            step(e, i == fw, "fetch");
        end
        e = '0; e.alu_src_b = 2'b11; e.illegal_op = (op > 4'd9);
        step(e, 1'($urandom_range(0, 1)), "decode");
        if (op == 4'd0) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
            step(e, 1'($urandom_range(0, 1)), "exec_r");
            e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
            step(e, 1'($urandom_range(0, 1)), "wb_r");
            exp_cnt++;
        end else if (op >= 4'd1 && op <= 4'd4) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_op = (op == 4'd2) ? 3'b100 : (op == 4'd3) ? 3'b101 :
                       (op == 4'd4) ? 3'b110 : 3'b000;
            step(e, 1'($urandom_range(0, 1)), "exec_i");
            e = '0; e.reg_write = 1'b1;
            step(e, 1'($urandom_range(0, 1)), "wb_i");
            exp_cnt++;
        end else if (op == 4'd5 || op == 4'd6) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step(e, 1'($urandom_range(0, 1)), "memadr");
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.iord = 1'b1;
                if (op == 4'd5) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                step(e, i == mw, (op == 4'd5) ? "memrd" : "memwr");
            end
            if (op == 4'd5) begin
                e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                step(e, 1'($urandom_range(0, 1)), "memwb");
            end
            exp_cnt++;
        end else if (op == 4'd7 || op == 4'd8) begin
            e = '0; e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_write_cond = 1'b1;
            e.pc_source = 2'b01; e.branch_ne = (op == 4'd8);
            step(e, 1'($urandom_range(0, 1)), "branch");
            exp_cnt++;
        end else if (op == 4'd9) begin
            e = '0; e.pc_write = 1'b1; e.pc_source = 2'b10;
            step(e, 1'($urandom_range(0, 1)), "jump");
            exp_cnt++;
        end
    endtask

    // Release reset at a falling edge; S_RESET for one cycle, then FETCH.
    task automatic release_reset(input string nm);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({nm, "_reset_state_outputs"}, 32'(actual()), 32'd0);
        chk({nm, "_reset_state_count"}, 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_fetch_after_reset"}, 32'({mem_read, iord}), 32'b10);
        exp_cnt = 0;
    endtask

    typedef struct {
        logic [3:0] op;
        int         mw;
        int         cycles;
        int         inc;
        int         ill;
    } vec_t;

    // Latency run driven only by observed requests, independent of the model.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        int ill = 0;
        int waits = v.mw;
        int c0 = int'(instr_count);
        bit done = 0;
        opcode = v.op;
        while (!done && cyc < 50) begin
            if (iord) begin
                mem_ready = (waits == 0);
                if (waits > 0) waits--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (illegal_op) ill++;
            @(posedge clk);
            #1;
            cyc++;
            if (mem_read && !iord) done = 1;
        end
        chk($sformatf("vec%0d_op%0d_cycles", idx, v.op), 32'(cyc), 32'(v.cycles));
        chk($sformatf("vec%0d_op%0d_count", idx, v.op),
            32'((int'(instr_count) - c0) & ((1 << CW) - 1)), 32'(v.inc));
        chk($sformatf("vec%0d_op%0d_illegal", idx, v.op), 32'(ill), 32'(v.ill));
        exp_cnt = int'(instr_count);
    endtask

    initial begin
        vec_t vecs[14];
        vecs = '{
            '{4'd0, 0, 4, 1, 0}, '{4'd1, 0, 4, 1, 0}, '{4'd2, 0, 4, 1, 0},
            '{4'd3, 0, 4, 1, 0}, '{4'd4, 0, 4, 1, 0}, '{4'd5, 0, 5, 1, 0},
            '{4'd6, 0, 4, 1, 0}, '{4'd7, 0, 3, 1, 0}, '{4'd8, 0, 3, 1, 0},
            '{4'd9, 0, 3, 1, 0}, '{4'hC, 0, 2, 0, 1}, '{4'hF, 0, 2, 0, 1},
            '{4'd5, 3, 8, 1, 0}, '{4'd6, 2, 6, 1, 0}
        };

        // Reset state.
        #2;
        chk("reset_outputs", 32'(actual()), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);
        repeat (2) @(posedge clk);
        release_reset("init");

        // R-type directed: alu_op 000,000,010 then write-back with rd; count 0 -> 1.
        exec(4'd0, 0, 0);
        chk("rtype_count_after", 32'(instr_count), 32'd1);

        // bne and illegal directed.
        exec(4'd8, 0, 0);
        exec(4'hC, 0, 0);
        chk("illegal_count_unchanged", 32'(instr_count), 32'd2);

        // lw with 3 wait cycles in MEMRD.
        exec(4'd5, 0, 3);

        // Table of latencies.
        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Randomised instruction stream.
        for (int n = 0; n < 200; n++)
            exec(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset mid-MEMRD: outputs must clear without waiting for a clock edge.
        opcode = 4'd5;
        mem_ready = 1'b1;
        @(posedge clk); #1;           // FETCH -> DECODE
        @(posedge clk); #1;           // DECODE -> MEMADR
        mem_ready = 1'b0;
        @(posedge clk); #1;           // MEMADR -> MEMRD
        chk("in_memrd", 32'({mem_read, iord}), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(actual()), 32'd0);
        chk("async_reset_count", 32'(instr_count), 32'd0);
        release_reset("mid");

        // Wrap: retire jumps until the counter is at its maximum, then one more.
        for (int n = 0; n < (1 << CW) - 1; n++) exec(4'd9, 0, 0);
        chk("count_at_max", 32'(instr_count), 32'((1 << CW) - 1));
        exec(4'd9, 0, 0);
        chk("count_wrapped", 32'(instr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
